// File: rtl/pipe_ctrl_param.sv
// In-order pipeline sequencer: valid+payload slots with stall, backpressure, branch flush, boot hold.
// Optional perf counters (stall_cnt, flush_cnt) enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl_param #(
  parameter int DATA_W     = 32,
  parameter int NUM_STAGES = 5,
  parameter int BR_STAGE   = 3,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         boot_up,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  input  logic                         stall_req,
  input  logic                         br_taken,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  input  logic                         out_ready,
  output logic [NUM_STAGES-1:0]        stage_valid,
  output logic [NUM_STAGES*DATA_W-1:0] stage_data,
  output logic [CNT_W-1:0]             retire_cnt,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             flush_cnt
);

  localparam int N = NUM_STAGES;

  logic [N-1:0]        valid_q;
  logic [N-1:0]        valid_d;
  logic [DATA_W-1:0]   data_q [N];
  logic                adv;
  logic                flush;

  // Advance, flush and accept decisions
  always_comb begin
    adv = rst_n && !boot_up && !stall_req &&
          (!valid_q[N-1] || out_ready);
    flush = br_taken && valid_q[BR_STAGE] && !boot_up;
    in_ready = adv && !flush;
  end

  // Next valid vector: shift, kill younger-than-branch, or boot clear
  always_comb begin
    valid_d = valid_q;
    if (boot_up) begin
      valid_d = '0;
    end else if (adv) begin
      valid_d = {valid_q[N-2:0], in_valid && in_ready};
      if (flush) begin
        for (int i = 0; i <= BR_STAGE; i++)
          valid_d[i] = 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < BR_STAGE; i++)
        valid_d[i] = 1'b0;
    end
  end

  // Valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Payload shifts with the pipe; bubbles carry stale data along
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        data_q[i] <= '0;
    end else if (adv) begin
      data_q[0] <= in_data;
      for (int i = 1; i < N; i++)
        data_q[i] <= data_q[i-1];
    end
  end

  // Retire count: output slot leaves only when the pipe advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retire_cnt <= '0;
    else if (boot_up)
      retire_cnt <= '0;
    else if (adv && valid_q[N-1])
      retire_cnt <= retire_cnt + CNT_W'(1);
  end

`ifdef PIPE_CTRL_PERF_EN
  // Stall cycles outside boot, and every applied flush pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!boot_up && !adv)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  assign out_valid   = valid_q[N-1];
  assign out_data    = data_q[N-1];
  assign stage_valid = valid_q;

  // Flatten slot payloads, slot i at [i*DATA_W +: DATA_W]
  always_comb begin
    stage_data = '0;
    for (int i = 0; i < N; i++)
      stage_data[i*DATA_W +: DATA_W] = data_q[i];
  end

endmodule
